// File: rtl/readout_layer.sv
// -----------------------------------------------------------------------------
// readout_layer
//   Multi-channel echo-state-network readout. For every output channel c it
//   forms sum_i d[i]*w(c,i) with a single time-shared signed multiplier, then
//   applies an arithmetic right shift and a (optionally rectifying) saturating
//   activation. The channels are processed one after the other. Results are
//   presented together under a valid/ready handshake.
//
// Ports
//   iClk      clock, rising edge
//   iRst      asynchronous, active-high reset
//   iValid    input vector and weights valid (sampled only while idle)
//   oReady    block is idle and will accept on the next edge with iValid=1
//   iData     RES_SIZE signed elements, element i at [i*DATA_W +: DATA_W]
//   iWeights  NUM_OUT*RES_SIZE signed weights, w(c,i) at
//             [(c*RES_SIZE+i)*WEIGHT_W +: WEIGHT_W]
//   oValid    oValue holds a complete result
//   iReady    consumer accepts the result (sampled only while done)
//   oValue    NUM_OUT signed results, channel c at [c*OUT_W +: OUT_W]
//   oBusy     block is not idle
// -----------------------------------------------------------------------------
module readout_layer #(
  parameter int RES_SIZE = 4,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int NUM_OUT  = 2,
  parameter int SHIFT    = 4,
  parameter int OUT_W    = 8,
  parameter int ACT_MODE = 0
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic                             iValid,
  output logic                             oReady,
  input  logic [RES_SIZE*DATA_W-1:0]       iData,
  input  logic [NUM_OUT*RES_SIZE*WEIGHT_W-1:0] iWeights,
  output logic                             oValid,
  input  logic                             iReady,
  output logic [NUM_OUT*OUT_W-1:0]         oValue,
  output logic                             oBusy
);

  localparam int ACC_W  = DATA_W + WEIGHT_W + $clog2(RES_SIZE) + 1;
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int IDX_W  = (RES_SIZE > 1) ? $clog2(RES_SIZE) : 1;
  localparam int CH_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC  = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_ACT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Saturation bounds expressed at accumulator width so the compare is signed
  // and lossless.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  logic [2:0]                          state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [CH_W-1:0]                     ch_q, ch_d;
  logic signed [ACC_W-1:0]             acc_q, acc_d;
  logic signed [ACC_W-1:0]             norm_q, norm_d;
  logic [RES_SIZE*DATA_W-1:0]          data_q, data_d;
  logic [NUM_OUT*RES_SIZE*WEIGHT_W-1:0] weights_q, weights_d;
  logic [OUT_W-1:0]                    val_q [NUM_OUT];
  logic [OUT_W-1:0]                    val_d [NUM_OUT];
  logic                                valid_q, valid_d;
  logic                                ready_q, ready_d;
  logic                                busy_q, busy_d;

  // Unpacked views of the latched operands so the MAC can index them directly.
  logic signed [DATA_W-1:0]   d_arr [RES_SIZE];
  logic signed [WEIGHT_W-1:0] w_arr [NUM_OUT][RES_SIZE];

  genvar gc, gi;
  generate
    for (gi = 0; gi < RES_SIZE; gi++) begin : g_data
      assign d_arr[gi] = data_q[gi*DATA_W +: DATA_W];
    end
    for (gc = 0; gc < NUM_OUT; gc++) begin : g_wch
      for (gi = 0; gi < RES_SIZE; gi++) begin : g_wel
        assign w_arr[gc][gi] = weights_q[(gc*RES_SIZE+gi)*WEIGHT_W +: WEIGHT_W];
      end
      assign oValue[gc*OUT_W +: OUT_W] = val_q[gc];
    end
  endgenerate

  logic signed [DATA_W-1:0]   d_sel_s;
  logic signed [WEIGHT_W-1:0] w_sel_s;
  logic signed [PROD_W-1:0]   d_ext_s, w_ext_s, prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [ACC_W-1:0]    act_s;
  logic [OUT_W-1:0]           sat_s;

  // Datapath: operand select, signed product and sign extension to the accumulator.
  always_comb begin
    d_sel_s    = d_arr[idx_q];
    w_sel_s    = w_arr[ch_q][idx_q];
    d_ext_s    = {{WEIGHT_W{d_sel_s[DATA_W-1]}}, d_sel_s};
    w_ext_s    = {{DATA_W{w_sel_s[WEIGHT_W-1]}}, w_sel_s};
    prod_s     = d_ext_s * w_ext_s;
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  // Activation: optional rectification, then clamp to the output range.
  always_comb begin
    if ((ACT_MODE == 1) && norm_q[ACC_W-1]) begin
      act_s = '0;
    end else begin
      act_s = norm_q;
    end
    if (act_s > SAT_MAX) begin
      sat_s = SAT_MAX[OUT_W-1:0];
    end else if (act_s < SAT_MIN) begin
      sat_s = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_s = act_s[OUT_W-1:0];
    end
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    norm_d    = norm_q;
    data_d    = data_q;
    weights_d = weights_q;
    val_d     = val_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (iValid) begin
          data_d    = iData;
          weights_d = iWeights;
          ch_d      = '0;
          idx_d     = '0;
          acc_d     = '0;
          ready_d   = 1'b0;
          state_d   = S_MAC;
        end else begin
          ready_d   = 1'b1;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext_s;
        if (idx_q == IDX_W'(RES_SIZE-1)) begin
          idx_d   = '0;
          state_d = S_NORM;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_NORM: begin
        // Arithmetic shift of a signed value rounds toward minus infinity.
        norm_d  = acc_q >>> SHIFT;
        state_d = S_ACT;
      end
      S_ACT: begin
        val_d[ch_q] = sat_s;
        if (ch_q == CH_W'(NUM_OUT-1)) begin
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings recover to a clean idle state.
        state_d = S_IDLE;
        idx_d   = '0;
        ch_d    = '0;
        acc_d   = '0;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      norm_q    <= '0;
      data_q    <= '0;
      weights_q <= '0;
      for (int c = 0; c < NUM_OUT; c++) begin
        val_q[c] <= '0;
      end
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      norm_q    <= norm_d;
      data_q    <= data_d;
      weights_q <= weights_d;
      for (int c = 0; c < NUM_OUT; c++) begin
        val_q[c] <= val_d[c];
      end
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign oValid = valid_q;
  assign oReady = ready_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_readout_layer.sv
// -----------------------------------------------------------------------------
// tb_readout_layer
//   Two readout_layer instances share all inputs: dut0 saturates only, dut1
//   rectifies first. Expected results come from a behavioural model and are
//   queued on accept, then popped and compared when oValid is observed.
// -----------------------------------------------------------------------------
module tb_readout_layer;

  localparam int RES = 4;
  localparam int DW  = 8;
  localparam int WW  = 8;
  localparam int NO  = 2;
  localparam int OW  = 8;
  localparam int SH  = 4;
  localparam int LAT = NO * (RES + 2);

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [RES*DW-1:0]    i_data;
  logic [NO*RES*WW-1:0] i_weights;
  logic              o_ready0, o_valid0, o_busy0;
  logic              o_ready1, o_valid1, o_busy1;
  logic [NO*OW-1:0]  o_value0, o_value1;

  int n_cmp;
  int n_bad;
  logic [NO*OW-1:0] exp_q0 [$];
  logic [NO*OW-1:0] exp_q1 [$];

  readout_layer #(.RES_SIZE(RES), .DATA_W(DW), .WEIGHT_W(WW), .NUM_OUT(NO),
                  .SHIFT(SH), .OUT_W(OW), .ACT_MODE(0)) dut0 (
    .iClk(clk), .iRst(rst), .iValid(i_valid), .oReady(o_ready0),
    .iData(i_data), .iWeights(i_weights), .oValid(o_valid0),
    .iReady(i_ready), .oValue(o_value0), .oBusy(o_busy0));

  readout_layer #(.RES_SIZE(RES), .DATA_W(DW), .WEIGHT_W(WW), .NUM_OUT(NO),
                  .SHIFT(SH), .OUT_W(OW), .ACT_MODE(1)) dut1 (
    .iClk(clk), .iRst(rst), .iValid(i_valid), .oReady(o_ready1),
    .iData(i_data), .iWeights(i_weights), .oValid(o_valid1),
    .iReady(i_ready), .oValue(o_value1), .oBusy(o_busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: integer dot product, floor shift, activation.
  function automatic logic [NO*OW-1:0] model(input logic [RES*DW-1:0] d,
                                             input logic [NO*RES*WW-1:0] w,
                                             input int mode);
    logic [NO*OW-1:0] r;
    int acc, n, dv, wv;
    r = '0;
    for (int c = 0; c < NO; c++) begin
      acc = 0;
      for (int i = 0; i < RES; i++) begin
        dv = $signed(d[i*DW +: DW]);
        wv = $signed(w[(c*RES+i)*WW +: WW]);
        acc = acc + dv * wv;
      end
      n = acc >>> SH;
      if (mode == 1 && n < 0) n = 0;
      if (n > 127) n = 127;
      else if (n < -128) n = -128;
      r[c*OW +: OW] = n[OW-1:0];
    end
    return r;
  endfunction

  function automatic logic [RES*DW-1:0] fill_d(input logic [DW-1:0] v);
    logic [RES*DW-1:0] r;
    for (int i = 0; i < RES; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NO*RES*WW-1:0] fill_w(input logic [WW-1:0] w0,
                                                  input logic [WW-1:0] w1);
    logic [NO*RES*WW-1:0] r;
    for (int i = 0; i < RES; i++) begin
      r[i*WW +: WW]       = w0;
      r[(RES+i)*WW +: WW] = w1;
    end
    return r;
  endfunction

  // Present one vector for a single accept edge and queue its expectations.
  task automatic do_accept(input logic [RES*DW-1:0] d, input logic [NO*RES*WW-1:0] w);
    i_data    = d;
    i_weights = w;
    i_valid   = 1'b1;
    exp_q0.push_back(model(d, w, 0));
    exp_q1.push_back(model(d, w, 1));
    @(posedge clk); #1;
    i_valid   = 1'b0;
  endtask

  // Count edges until dut0 reports a result; bounded so a stuck DUT cannot hang.
  task automatic wait_valid(output int n);
    n = 0;
    while (o_valid0 !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_weights = '0;
    #12;
    n_cmp++;
    if ({o_ready0, o_valid0, o_busy0, o_value0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_dut0: got rdy/vld/busy/val=%b%b%b %h, need 100 0000",
               o_ready0, o_valid0, o_busy0, o_value0);
    end
    n_cmp++;
    if ({o_ready1, o_valid1, o_busy1, o_value1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_dut1: got rdy/vld/busy/val=%b%b%b %h, need 100 0000",
               o_ready1, o_valid1, o_busy1, o_value1);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stimulus of the basic case; also checks handshake timing around it.
  task automatic test_basic(input string tag);
    int n;
    logic [NO*OW-1:0] e0, e1;
    i_ready = 1'b1;
    n_cmp++;
    if (o_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL %s_ready_before: got %b, need 1", tag, o_ready0);
    end
    do_accept(fill_d(8'd1), fill_w(8'd16, 8'hF0));
    n_cmp++;
    if ({o_ready0, o_busy0} !== 2'b01) begin
      n_bad++; $display("FAIL %s_busy_after_accept: got rdy/busy=%b%b, need 01", tag, o_ready0, o_busy0);
    end
    wait_valid(n);
    n_cmp++;
    if (n != LAT) begin
      n_bad++; $display("FAIL %s_latency: got %0d cycles, need %0d", tag, n, LAT);
    end
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    n_cmp++;
    if (o_value0 !== e0 || e0 !== 16'hFC04) begin
      n_bad++; $display("FAIL %s_value_sat: got %h, need %h", tag, o_value0, 16'hFC04);
    end
    n_cmp++;
    if (o_valid1 !== 1'b1 || o_value1 !== e1) begin
      n_bad++; $display("FAIL %s_value_relu: got vld=%b %h, need vld=1 %h", tag, o_valid1, o_value1, e1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({o_valid0, o_ready0, o_busy0} !== 3'b010) begin
      n_bad++; $display("FAIL %s_release: got vld/rdy/busy=%b%b%b, need 010", tag, o_valid0, o_ready0, o_busy0);
    end
  endtask

  task automatic test_relu;
    int n;
    logic [NO*OW-1:0] e1;
    do_accept(fill_d(8'd1), fill_w(8'd16, 8'hF0));
    wait_valid(n);
    void'(exp_q0.pop_front());
    e1 = exp_q1.pop_front();
    n_cmp++;
    if (o_value1 !== 16'h0004 || e1 !== 16'h0004) begin
      n_bad++; $display("FAIL relu_neg_to_zero: got %h (model %h), need 0004", o_value1, e1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    int n;
    logic [NO*OW-1:0] e0, e1;
    do_accept(fill_d(8'd127), fill_w(8'd127, 8'h80));
    wait_valid(n);
    e0 = exp_q0.pop_front();
    e1 = exp_q1.pop_front();
    n_cmp++;
    if (o_value0 !== e0 || o_value0 !== 16'h807F) begin
      n_bad++; $display("FAIL saturate: got %h, need 807F", o_value0);
    end
    n_cmp++;
    if (o_value1 !== e1 || o_value1 !== 16'h007F) begin
      n_bad++; $display("FAIL saturate_relu: got %h, need 007F", o_value1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_floor;
    int n;
    logic [RES*DW-1:0]    d;
    logic [NO*RES*WW-1:0] w;
    d = '0; d[DW-1:0] = 8'hFF;
    w = '0; w[WW-1:0] = 8'h01;
    do_accept(d, w);
    wait_valid(n);
    n_cmp++;
    if (o_value0 !== exp_q0.pop_front() || o_value0 !== 16'h00FF) begin
      n_bad++; $display("FAIL floor_shift: got %h, need 00FF", o_value0);
    end
    n_cmp++;
    if (o_value1 !== exp_q1.pop_front() || o_value1 !== 16'h0000) begin
      n_bad++; $display("FAIL floor_relu: got %h, need 0000", o_value1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    logic [NO*OW-1:0] e0;
    i_ready = 1'b0;
    do_accept(fill_d(8'd3), fill_w(8'd20, 8'hEC));
    // iValid pulses with different data while busy must not be accepted.
    i_data = fill_d(8'h55); i_weights = fill_w(8'h7F, 8'h7F); i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    i_valid = 1'b0;
    wait_valid(n);
    n_cmp++;
    if (n + 3 != LAT) begin
      n_bad++; $display("FAIL bp_latency: got %0d cycles, need %0d", n + 3, LAT);
    end
    e0 = exp_q0.pop_front();
    void'(exp_q1.pop_front());
    for (int k = 0; k < 5; k++) begin
      i_valid = k[0];
      @(posedge clk); #1;
      n_cmp++;
      if ({o_valid0, o_ready0, o_busy0} !== 3'b101 || o_value0 !== e0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got vld/rdy/busy=%b%b%b %h, need 101 %h",
                 k, o_valid0, o_ready0, o_busy0, o_value0, e0);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_valid0, o_ready0, o_busy0} !== 3'b010) begin
      n_bad++; $display("FAIL bp_release: got vld/rdy/busy=%b%b%b, need 010", o_valid0, o_ready0, o_busy0);
    end
  endtask

  task automatic test_reset_mid;
    do_accept(fill_d(8'd2), fill_w(8'd9, 8'd9));
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({o_valid0, o_ready0, o_busy0, o_value0} !== {3'b010, 16'h0000}) begin
      n_bad++; $display("FAIL reset_mid: got vld/rdy/busy=%b%b%b %h, need 010 0000",
                        o_valid0, o_ready0, o_busy0, o_value0);
    end
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_basic("after_reset");
  endtask

  // iValid held high: each vector is accepted on the first idle edge.
  task automatic test_back_to_back;
    int n;
    logic [RES*DW-1:0]    d;
    logic [NO*RES*WW-1:0] w;
    i_ready = 1'b1;
    d = $urandom; w = {$urandom, $urandom};
    i_data = d; i_weights = w; i_valid = 1'b1;
    exp_q0.push_back(model(d, w, 0)); exp_q1.push_back(model(d, w, 1));
    @(posedge clk); #1;
    wait_valid(n);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (o_value0 !== exp_q0.pop_front() || o_value1 !== exp_q1.pop_front()) begin
        n_bad++; $display("FAIL b2b_value%0d: got %h/%h", k, o_value0, o_value1);
      end
      d = $urandom; w = {$urandom, $urandom};
      i_data = d; i_weights = w;
      exp_q0.push_back(model(d, w, 0)); exp_q1.push_back(model(d, w, 1));
      @(posedge clk); #1;
      wait_valid(n);
      n_cmp++;
      if (n != LAT + 1) begin
        n_bad++; $display("FAIL b2b_period%0d: got %0d, need %0d", k, n + 1, LAT + 2);
      end
    end
    i_valid = 1'b0;
    n_cmp++;
    if (o_value0 !== exp_q0.pop_front() || o_value1 !== exp_q1.pop_front()) begin
      n_bad++; $display("FAIL b2b_last: got %h/%h", o_value0, o_value1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic("basic");
    test_saturate();
    test_relu();
    test_floor();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
